hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have id_rs1_addr, id_rs2_addr  input  5 each  source register addresses of the instruction in ID.
REQ-004 SHALL have id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1/rs2.
REQ-005 SHALL have ex_rd_addr  input  5  destination register address of the instruction in EX.
REQ-006 SHALL have ex_DM_OE  input  1  instruction in EX is a load.
REQ-007 SHALL have ex_redirect  input  1  taken branch, jal or jalr resolved in EX.
REQ-008 SHALL have ex_target  input  32  redirect address from EX.
REQ-009 SHALL have imem_busy, dmem_busy  input  1 each  AXI instruction/data access outstanding.
REQ-010 SHALL have pc_stall, if_id_stall  output  1 each  hold PC / IF-ID.
REQ-011 SHALL have if_id_flush, id_ex_flush  output  1 each  squash IF-ID / ID-EX (id_ex_flush drives the ID-EX i_flush).
REQ-012 SHALL have id_ex_bubble  output  1  insert bubble into ID-EX (drives i_ex_stall).
REQ-013 SHALL have pipe_freeze  output  1  hold ID-EX, EX-MEM, MEM-WB.
REQ-014 SHALL have redirect_valid  output  1  and redirect_pc  output  32  PC redirect request.
REQ-015 SHALL have perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt  output  32 each  event counters.

Function
REQ-016 SHALL implement two states, RUN and FREEZE, plus a pending-redirect flag pend and a 32-bit register pend_pc.
REQ-017 SHALL compute all control outputs combinationally in the same cycle as their inputs (zero latency).
REQ-018 SHALL detect load-use as: ex_DM_OE=1, ex_rd_addr!=0, and (id_rs1_used and id_rs1_addr==ex_rd_addr) or (id_rs2_used and id_rs2_addr==ex_rd_addr).
REQ-019 SHALL assert freeze when imem_busy or dmem_busy is 1, driving pipe_freeze=1, pc_stall=1 and if_id_stall=1, with all flush, bubble and redirect outputs 0; priority: freeze > redirect > load-use.
REQ-020 SHALL move RUN->FREEZE when freeze is asserted, and FREEZE->RUN on the first cycle in which both busy inputs are 0.
REQ-021 SHALL, while freeze is active and pend=0, capture ex_redirect=1 by setting pend=1 and pend_pc=ex_target. Later redirects during the same freeze SHALL be ignored.
REQ-022 SHALL, with no freeze, set redirect_valid = pend or ex_redirect, with redirect_pc = pend_pc if pend else ex_target; when redirect_valid=1, assert if_id_flush=1 and id_ex_flush=1 and clear pend at the next edge.
REQ-023 SHALL, on load-use with no freeze and no redirect, assert pc_stall=1, if_id_stall=1 and id_ex_bubble=1 for exactly the cycle the condition holds.
REQ-024 SHALL drive redirect_pc=0 whenever redirect_valid=0.

Reset
REQ-025 SHALL force state=RUN, pend=0, pend_pc=0 and all counters to 0 while rst=1. All outputs SHALL be 0 during reset.
REQ-026 SHALL discard a pending redirect on reset asserted mid-freeze; the first cycle after release is in RUN with pend=0.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, increment saturating counters (hold at 0xFFFFFFFF) once per cycle of: load-use stall (perf_stall_cnt), redirect_valid (perf_flush_cnt), freeze (perf_freeze_cnt).
REQ-028 SHALL, without HAZARD_PERF_CNT_EN, keep the counter ports present and tied to 0, with no counter flops.

Verification
REQ-029 SHALL verify load-use: ex_DM_OE=1, ex_rd_addr=5, id_rs1_used=1, id_rs1_addr=5 -> pc_stall=if_id_stall=id_ex_bubble=1 in that cycle. With ex_rd_addr=0 -> all 0.
REQ-030 SHALL verify redirect: ex_redirect=1, ex_target=0x0000_0100 -> redirect_valid=1, redirect_pc=0x100, if_id_flush=id_ex_flush=1 in the same cycle.
REQ-031 SHALL verify freeze capture: dmem_busy=1 for 4 cycles with ex_redirect=1 (target 0x200) on cycle 2 then 0 -> no redirect during freeze; redirect_valid=1 with pc 0x200 for exactly 1 cycle after dmem_busy falls.
REQ-032 SHALL verify priority: redirect and load-use simultaneous -> flushes asserted, id_ex_bubble=0. Freeze plus redirect simultaneous -> only the freeze outputs asserted.
REQ-033 SHALL verify reset mid-freeze with pend=1: rst pulse -> after release, redirect_valid stays 0 and the counters read 0.
REQ-034 SHALL verify saturation (HAZARD_PERF_CNT_EN defined): force perf_freeze_cnt=0xFFFFFFFE, hold imem_busy=1 for 3 cycles -> counter reads 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush and AXI-busy freeze with deferred redirect.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush/freeze event counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_DM_OE,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_bubble,
  output logic        pipe_freeze,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt
);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic freeze;
  logic load_use;
  logic redirect;
  logic lu_stall;

  always_comb begin
    freeze   = imem_busy | dmem_busy;
    load_use = ex_DM_OE && (ex_rd_addr != 5'd0) &&
               ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    // A redirect captured during a freeze replays on the first unfrozen cycle.
    redirect = !freeze && (pend_q || ex_redirect);
    lu_stall = !freeze && !redirect && load_use;
  end

  // Outputs are zero-latency; rst gates them so nothing leaks out during reset.
  always_comb begin
    pipe_freeze    = !rst && freeze;
    pc_stall       = !rst && (freeze || lu_stall);
    if_id_stall    = !rst && (freeze || lu_stall);
    if_id_flush    = !rst && redirect;
    id_ex_flush    = !rst && redirect;
    id_ex_bubble   = !rst && lu_stall;
    redirect_valid = !rst && redirect;
    redirect_pc    = 32'd0;
    if (redirect_valid) redirect_pc = pend_q ? pend_pc_q : ex_target;
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d   = state_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      RUN:    if (freeze)  state_d = FREEZE;
      FREEZE: if (!freeze) state_d = RUN;
      default:             state_d = RUN;
    endcase
    if (freeze && !pend_q && ex_redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = ex_target;
    end else if (redirect) begin
      pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      freeze_cnt_q <= 32'd0;
    end else begin
      if (lu_stall && (stall_cnt_q  != 32'hFFFF_FFFF)) stall_cnt_q  <= stall_cnt_q  + 32'd1;
      if (redirect && (flush_cnt_q  != 32'hFFFF_FFFF)) flush_cnt_q  <= flush_cnt_q  + 32'd1;
      if (freeze   && (freeze_cnt_q != 32'hFFFF_FFFF)) freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_freeze_cnt = freeze_cnt_q;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_flush_cnt  = 32'd0;
  assign perf_freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change 1ns after posedge, outputs checked at negedge.
// Define HAZARD_PERF_CNT_EN to also exercise the event counters and saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_DM_OE, ex_redirect;
  logic [31:0] ex_target;
  logic        imem_busy, dmem_busy;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_bubble;
  logic        pipe_freeze, redirect_valid;
  logic [31:0] redirect_pc, perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_bubble, pipe_freeze, redirect_valid}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1100100;
  localparam logic [6:0] FLUSH = 7'b0011001;
  localparam logic [6:0] FRZ   = 7'b1100010;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd_addr      (ex_rd_addr),
    .ex_DM_OE        (ex_DM_OE),
    .ex_redirect     (ex_redirect),
    .ex_target       (ex_target),
    .imem_busy       (imem_busy),
    .dmem_busy       (dmem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_freeze     (pipe_freeze),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp, input logic [31:0] exp_pc);
    check({tag, "_ctl"}, {25'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
                          id_ex_bubble, pipe_freeze, redirect_valid}, {25'd0, exp});
    check({tag, "_pc"}, redirect_pc, exp_pc);
  endtask

  task automatic check_cnt(input string tag, input int st, input int fl, input int fz);
    check({tag, "_stall_cnt"},  perf_stall_cnt,  st);
    check({tag, "_flush_cnt"},  perf_flush_cnt,  fl);
    check({tag, "_freeze_cnt"}, perf_freeze_cnt, fz);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_DM_OE   = 1'b0;
    ex_redirect = 1'b0; ex_target   = 32'd0;
    imem_busy   = 1'b0; dmem_busy   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_DM_OE = 1'b1; ex_rd_addr = rd; id_rs1_used = 1'b1; id_rs1_addr = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every hazard source active: all outputs must stay low.
    rst = 1'b1;
    clear_inputs();
    set_load_use(5'd5);
    ex_redirect = 1'b1; ex_target = 32'h100; dmem_busy = 1'b1;
    #2;
    check_ctl("reset", NONE, 32'd0);
    check_cnt("reset", 0, 0, 0);

    step(); rst = 1'b0; clear_inputs(); #4;
    check_ctl("idle", NONE, 32'd0);

    step(); set_load_use(5'd5); #4;
    check_ctl("lu_rs1", STALL, 32'd0);
    step(); ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; #4;
    check_ctl("lu_rd0", NONE, 32'd0);
    step(); clear_inputs(); ex_DM_OE = 1'b1; ex_rd_addr = 5'd9;
    id_rs2_used = 1'b1; id_rs2_addr = 5'd9; id_rs1_addr = 5'd9; #4;
    check_ctl("lu_rs2", STALL, 32'd0);
    step(); id_rs2_used = 1'b0; #4;
    check_ctl("lu_unused", NONE, 32'd0);
    step(); id_rs2_used = 1'b1; ex_DM_OE = 1'b0; #4;
    check_ctl("lu_noload", NONE, 32'd0);

    step(); clear_inputs(); ex_redirect = 1'b1; ex_target = 32'h100; #4;
    check_ctl("redir", FLUSH, 32'h100);
    step(); ex_redirect = 1'b0; #4;
    check_ctl("redir_off", NONE, 32'd0);
    step(); ex_redirect = 1'b1; ex_target = 32'h180; set_load_use(5'd7); #4;
    check_ctl("prio_redir_lu", FLUSH, 32'h180);

    // Freeze beats redirect; the first captured target wins over a later one.
    step(); clear_inputs(); imem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h300; #4;
    check_ctl("prio_frz_redir", FRZ, 32'd0);
    step(); ex_target = 32'h340; #4;
    check_ctl("frz_second_redir", FRZ, 32'd0);
    step(); clear_inputs(); #4;
    check_ctl("frz_replay", FLUSH, 32'h300);
    step(); #4;
    check_ctl("frz_replay_once", NONE, 32'd0);

    // dmem_busy for 4 cycles, redirect to 0x200 on cycle 2 only.
    step(); clear_inputs(); dmem_busy = 1'b1; #4;
    check_ctl("cap_c1", FRZ, 32'd0);
    step(); ex_redirect = 1'b1; ex_target = 32'h200; #4;
    check_ctl("cap_c2", FRZ, 32'd0);
    step(); ex_redirect = 1'b0; #4;
    check_ctl("cap_c3", FRZ, 32'd0);
    step(); #4;
    check_ctl("cap_c4", FRZ, 32'd0);
    step(); dmem_busy = 1'b0; #4;
    check_ctl("cap_release", FLUSH, 32'h200);
    step(); #4;
    check_ctl("cap_after", NONE, 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    check_cnt("events", 2, 4, 6);
`else
    check_cnt("tied_off", 0, 0, 0);
`endif

    // Reset while frozen with a pending redirect must discard it.
    step(); dmem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h400; #4;
    check_ctl("rst_pend_frz", FRZ, 32'd0);
    step(); ex_redirect = 1'b0; rst = 1'b1; #4;
    check_ctl("rst_mid_frz", NONE, 32'd0);
    step(); rst = 1'b0; dmem_busy = 1'b0; #4;
    check_ctl("post_rst", NONE, 32'd0);
    check_cnt("post_rst", 0, 0, 0);

`ifdef HAZARD_PERF_CNT_EN
    step();
    force dut.freeze_cnt_q = 32'hFFFF_FFFE;
    #4;
    release dut.freeze_cnt_q;
    imem_busy = 1'b1;
    repeat (3) step();
    imem_busy = 1'b0;
    #4;
    check("freeze_cnt_sat", perf_freeze_cnt, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
